// File: rtl/plic_lite_m_if.sv
// Register-port bundle for plic_lite_m: single-cycle request, ack one cycle later.
interface plic_lite_m_if;
    logic        req;
    logic        wen;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    modport master (output req, wen, addr, wdata, input  rdata, ack);
    modport slave  (input  req, wen, addr, wdata, output rdata, ack);
endinterface

// File: rtl/plic_lite_m.sv
// Machine-mode PLIC: level gateways, priority/threshold arbitration, claim/complete
// register port, feeding the external-interrupt inputs of the priv block.
module plic_lite_m #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_SRC-1:0] irq_src,
    plic_lite_m_if.slave       bus,
    output logic               plic_ext_int_m,
    output logic               plic_clear_ext_int_m
);
    logic [NUM_SRC-1:0]             sync1_q, sync2_q;
    logic [NUM_SRC-1:0]             pending_q, pending_d, inflight_q, inflight_d;
    logic [NUM_SRC-1:0]             enable_q, elig, best_oh, claim_oh, cmpl_oh;
    logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q;
    logic [PRIO_W-1:0]              thresh_q, best_prio;
    logic [4:0]                     best_id;
    logic [1:0]                     vld_pipe_q;
    logic [31:0]                    rd_val, data1_q, rdata_q;
    logic                           ext_q, ext_d, clr_q, clr_d;
    logic                           acc, claim, complete;
    logic [5:0]                     widx;
    logic                           unused_addr;

    assign unused_addr = ^bus.addr[1:0];
    assign widx        = bus.addr[7:2];
    // One access in flight: requests during the ack pipeline are dropped.
    assign acc         = bus.req & ~vld_pipe_q[0] & ~vld_pipe_q[1];
    assign claim       = acc & ~bus.wen & (widx == 6'd35);
    assign complete    = acc &  bus.wen & (widx == 6'd35);

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        assign elig[i]    = pending_q[i] & enable_q[i] & (prio_q[i] > thresh_q);
        assign best_oh[i] = (best_id == 5'(i + 1));
        assign cmpl_oh[i] = complete & (bus.wdata == 32'(i + 1));
    end

    // Strict '>' keeps the lowest id on priority ties.
    always_comb begin
        best_id   = '0;
        best_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (elig[i] && (best_id == 5'd0 || prio_q[i] > best_prio)) begin
                best_id   = 5'(i + 1);
                best_prio = prio_q[i];
            end
        end
    end

    assign claim_oh   = claim ? best_oh : '0;
    // Claim clear wins over the gateway set in the same cycle.
    assign pending_d  = (pending_q | (sync2_q & ~inflight_q)) & ~claim_oh;
    assign inflight_d = (inflight_q & ~cmpl_oh) | claim_oh;
    assign ext_d      = |(elig & ~claim_oh);
    assign clr_d      = (|claim_oh) & ~ext_d;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (widx == 6'(i + 1)) rd_val = 32'(prio_q[i]);
        case (widx)
            6'd32:   rd_val = 32'({pending_q, 1'b0});
            6'd33:   rd_val = 32'({enable_q, 1'b0});
            6'd34:   rd_val = 32'(thresh_q);
            6'd35:   rd_val = 32'(best_id);
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            pending_q  <= '0;
            inflight_q <= '0;
            enable_q   <= '0;
            prio_q     <= '0;
            thresh_q   <= '0;
            ext_q      <= 1'b0;
            clr_q      <= 1'b0;
            vld_pipe_q <= '0;
            data1_q    <= '0;
            rdata_q    <= '0;
        end else begin
            sync1_q    <= irq_src;
            sync2_q    <= sync1_q;
            pending_q  <= pending_d;
            inflight_q <= inflight_d;
            ext_q      <= ext_d;
            clr_q      <= clr_d;
            vld_pipe_q <= {vld_pipe_q[0], acc};
            data1_q    <= (acc & ~bus.wen) ? rd_val : '0;
            rdata_q    <= vld_pipe_q[0] ? data1_q : '0;
            if (acc && bus.wen) begin
                for (int i = 0; i < NUM_SRC; i++)
                    if (widx == 6'(i + 1)) prio_q[i] <= bus.wdata[PRIO_W-1:0];
                if (widx == 6'd33) enable_q <= bus.wdata[NUM_SRC:1];
                if (widx == 6'd34) thresh_q <= bus.wdata[PRIO_W-1:0];
            end
        end
    end

    assign bus.ack              = vld_pipe_q[1];
    assign bus.rdata            = rdata_q;
    assign plic_ext_int_m       = ext_q;
    assign plic_clear_ext_int_m = clr_q;
endmodule

// File: tb/tb_plic_lite_m.sv
// Randomized scoreboard bench for plic_lite_m against a transaction-level PLIC model.
module tb_plic_lite_m;
    localparam int N  = 8;
    localparam int PW = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] irq = '0;
    logic         ext, clr;

    plic_lite_m_if bus();

    plic_lite_m #(.NUM_SRC(N), .PRIO_W(PW)) dut (
        .CLK(clk), .RST(rst), .irq_src(irq), .bus(bus),
        .plic_ext_int_m(ext), .plic_clear_ext_int_m(clr)
    );

    always #5 clk = ~clk;

    int passes = 0, total = 0;
    int ack_cnt = 0, clr_cnt = 0, exp_pulse = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    // Reference model: abstract PLIC state, updated once per transaction.
    int m_prio[1:N];
    bit m_en[1:N], m_pend[1:N], m_infl[1:N];
    int m_thr;

    function automatic bit m_elig(int id);
        return m_pend[id] && m_en[id] && (m_prio[id] > m_thr);
    endfunction

    function automatic int m_best();
        for (int p = (1 << PW) - 1; p > 0; p--)
            for (int id = 1; id <= N; id++)
                if (m_elig(id) && m_prio[id] == p) return id;
        return 0;
    endfunction

    function automatic bit m_any();
        for (int id = 1; id <= N; id++) if (m_elig(id)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_settle();
        for (int id = 1; id <= N; id++) if (irq[id-1] && !m_infl[id]) m_pend[id] = 1'b1;
    endfunction

    function automatic void m_reset();
        for (int id = 1; id <= N; id++) begin
            m_prio[id] = 0; m_en[id] = 0; m_pend[id] = 0; m_infl[id] = 0;
        end
        m_thr = 0;
    endfunction

    function automatic logic [31:0] m_read(input logic [7:0] a);
        logic [31:0] v = '0;
        int idx = int'(a[7:2]);
        if (idx >= 1 && idx <= N) return 32'(m_prio[idx]);
        case (idx)
            32: for (int id = 1; id <= N; id++) v[id] = m_pend[id];
            33: for (int id = 1; id <= N; id++) v[id] = m_en[id];
            34: v = 32'(m_thr);
            35: v = 32'(m_best());
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic void m_apply(input logic w, input logic [7:0] a, input logic [31:0] wd);
        int idx = int'(a[7:2]);
        int b;
        if (!w) begin
            if (idx == 35) begin
                b = m_best();
                if (b != 0) begin
                    m_pend[b] = 0; m_infl[b] = 1;
                    exp_pulse = m_any() ? 0 : 1;
                end
            end
        end else if (idx >= 1 && idx <= N) m_prio[idx] = int'(wd) & ((1 << PW) - 1);
        else if (idx == 33) for (int id = 1; id <= N; id++) m_en[id] = wd[id];
        else if (idx == 34) m_thr = int'(wd) & ((1 << PW) - 1);
        else if (idx == 35 && wd >= 1 && wd <= N && m_infl[int'(wd)]) m_infl[int'(wd)] = 0;
    endfunction

    typedef struct packed { logic rd; logic [7:0] a; logic [31:0] d; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic ext_prev = 1'b0, clr_prev = 1'b0;

    // Monitor: pops one expectation per ack; checks clear-pulse shape.
    always @(negedge clk) begin
        if (bus.ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) chk("unexpected_ack", 32'(bus.ack), 32'd0);
            else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rd) chk($sformatf("rdata@%0h", mon_e.a), bus.rdata, mon_e.d);
            end
        end
        if (clr) begin
            clr_cnt++;
            chk("clr_with_ext_fall", 32'({ext_prev, ext}), 32'b10);
            chk("clr_single_cycle", 32'(clr_prev), 32'd0);
        end
        ext_prev = ext;
        clr_prev = clr;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] wd);
        exp_t e;
        e.rd = !w; e.a = a; e.d = w ? 32'd0 : m_read(a);
        exp_q.push_back(e);
        exp_pulse = 0;
        m_apply(w, a, wd);
        bus.req = 1'b1; bus.wen = w; bus.addr = a; bus.wdata = wd;
        tick();
        bus.req = 1'b0; bus.wen = 1'b0;
    endtask

    task automatic access(input logic w, input logic [7:0] a, input logic [31:0] wd);
        int a0 = ack_cnt;
        int p0 = clr_cnt;
        issue(w, a, wd);
        for (int i = 0; i < 4 && ack_cnt == a0; i++) tick();
        chk("ack_seen", 32'(ack_cnt - a0), 32'd1);
        repeat (5) tick();
        m_settle();
        chk("ext_level", 32'(ext), 32'(m_any()));
        chk("clr_pulses", 32'(clr_cnt - p0), 32'(exp_pulse));
    endtask

    task automatic set_lines(input logic [N-1:0] v);
        irq = v;
        repeat (6) tick();
        m_settle();
        chk("ext_after_lines", 32'(ext), 32'(m_any()));
    endtask

    task automatic do_reset(input logic [N-1:0] hold);
        rst = 1'b1; irq = hold;
        tick(); tick();
        chk("rst_ext", 32'(ext), 32'd0);
        chk("rst_clr", 32'(clr), 32'd0);
        chk("rst_ack", 32'(bus.ack), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        irq = '0; rst = 1'b0;
        exp_q.delete();
        m_reset();
        tick(); tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a0, p0;
        bus.req = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0;
        m_reset();
        do_reset('1);
        access(0, 8'h84, 0); access(0, 8'h88, 0); access(0, 8'h80, 0);

        // Basic flow with exact gateway latency.
        access(1, 8'h0C, 5); access(1, 8'h84, 32'h08); access(1, 8'h88, 0);
        irq[2] = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            tick();
            chk($sformatf("latency_ext_k+%0d", t), 32'(ext), 32'(t == 4));
        end
        m_settle();
        access(0, 8'h8C, 0);
        access(0, 8'h80, 0);
        access(1, 8'h8C, 7);
        a0 = ack_cnt;
        issue(1, 8'h8C, 3);
        chk("repend_n", 32'(ext), 32'd0);
        tick(); chk("repend_n+1", 32'(ext), 32'd0);
        tick(); chk("repend_n+2", 32'(ext), 32'd1);
        repeat (4) tick();
        m_settle();
        chk("repend_ack", 32'(ack_cnt - a0), 32'd1);
        access(0, 8'h80, 0);

        // Arbitration: ties to lowest id, single clear pulse at the end.
        do_reset('0);
        access(1, 8'h04, 2); access(1, 8'h08, 6); access(1, 8'h10, 6); access(1, 8'h84, 32'h16);
        set_lines(8'h0B);
        p0 = clr_cnt;
        repeat (4) access(0, 8'h8C, 0);
        chk("arb_one_pulse", 32'(clr_cnt - p0), 32'd1);
        access(0, 8'h80, 0);

        // Threshold and priority 0.
        do_reset('0);
        access(1, 8'h0C, 5); access(1, 8'h84, 32'h08); access(1, 8'h88, 5);
        set_lines(8'h04);
        access(0, 8'h8C, 0); access(0, 8'h80, 0);
        access(1, 8'h0C, 0); access(0, 8'h8C, 0);

        // Request during the ack cycle is dropped.
        access(1, 8'h0C, 5); access(1, 8'h88, 0);
        a0 = ack_cnt;
        issue(0, 8'h84, 0);
        tick();
        bus.req = 1'b1; bus.wen = 1'b0; bus.addr = 8'h8C;
        tick();
        bus.req = 1'b0;
        repeat (4) tick();
        chk("b2b_single_ack", 32'(ack_cnt - a0), 32'd1);
        chk("b2b_no_claim", 32'(ext), 32'd1);

        // Reset the cycle after a claim request: no ack, state cleared.
        a0 = ack_cnt;
        issue(0, 8'h8C, 0);
        rst = 1'b1; irq = '0;
        tick(); tick();
        rst = 1'b0;
        exp_q.delete();
        m_reset();
        repeat (4) tick();
        chk("midrst_no_ack", 32'(ack_cnt - a0), 32'd0);
        chk("midrst_ext", 32'(ext), 32'd0);
        access(0, 8'h80, 0); access(0, 8'h84, 0); access(0, 8'h0C, 0);

        // Randomized traffic.
        repeat (150) begin
            case ($urandom_range(0, 7))
                0:       set_lines(N'($urandom));
                1:       access(1, 8'(4 * $urandom_range(1, N)), $urandom);
                2:       access(1, 8'h84, $urandom);
                3:       access(1, 8'h88, $urandom_range(0, 4));
                4, 5:    access(0, 8'(8'h8C | 8'($urandom_range(0, 3))), 0);
                6:       access(1, 8'h8C, $urandom_range(0, 10));
                default: access(1'($urandom_range(0, 1)), 8'($urandom), $urandom);
            endcase
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule

// File: doc/plic_lite_m.md
Name: plic_lite_m

Overview:
- Minimal machine-mode platform-level interrupt controller that drives the external-interrupt inputs of the priv 1.11 block.
- Outputs `plic_ext_int_m` (level) and `plic_clear_ext_int_m` (one-cycle pulse).
- Gates, prioritises and arbitrates up to `NUM_SRC` peripheral interrupt lines.
- Software accesses it through a small memory-mapped register port implementing claim/complete.

Parameters:
- `NUM_SRC`, 8, number of interrupt sources; ids 1..`NUM_SRC`, id 0 reserved; legal range 1..31.
- `PRIO_W`, 3, priority field width; priority 0 means never interrupt.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  synchronous, active-high reset.
- `irq_src`  in  `NUM_SRC`  asynchronous level interrupt lines; bit i-1 is source id i.
- `req`  in  1  register access request, single-cycle pulse.
- `wen`  in  1  1 = write, 0 = read; qualified by `req`.
- `addr`  in  8  byte address; word aligned, `addr[1:0]` ignored.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data; valid while `ack` = 1.
- `ack`  out  1  access completion, one cycle after `req`.
- `plic_ext_int_m`  out  1  machine external interrupt pending, to priv block.
- `plic_clear_ext_int_m`  out  1  one-cycle clear pulse, to priv block.

Behaviour:
- Reset (`RST` high at a `CLK` edge) clears every register and output: `rdata`=0, `ack`=0, `plic_ext_int_m`=0, `plic_clear_ext_int_m`=0, all priority/enable/threshold/pending/in-flight/synchroniser state = 0.
- Reset mid-access drops the access and produces no `ack`.
- Synchroniser: two flops per `irq_src` bit; `sync[i]` is the second-stage output.
- Gateway, per source:
  - `pending[i]` sets when `sync[i]`=1 and `inflight[i]`=0.
  - `pending[i]` clears and `inflight[i]` sets when a claim returns id i.
  - A complete write of id i clears `inflight[i]`; a still-high line re-pends on the next cycle.
- Eligible(i) = `pending[i]` & `enable[i]` & (`prio[i]` > `threshold`).
- Arbitration is combinational over the registered state:
  - Best = eligible source with the highest priority.
  - Ties go to the lowest id.
  - Best = 0 if none is eligible.
- `plic_ext_int_m` is registered: next value = (any eligible), computed after this cycle's claim effect.
- Latency: `irq_src` rising at edge k gives `pending` set at edge k+3 and `plic_ext_int_m` set at edge k+4.
- Register map (byte offset):
  - 4*id for id 1..`NUM_SRC`: PRIORITY[id], RW, low `PRIO_W` bits, upper bits read 0.
  - 0x80: PENDING, RO; bit id = `pending[id]`, bit 0 = 0.
  - 0x84: ENABLE, RW; bit id; bit 0 and bits above `NUM_SRC` are hardwired 0.
  - 0x88: THRESHOLD, RW, `PRIO_W` bits.
  - 0x8C: CLAIM/COMPLETE.
    - Read = claim: returns the Best id.
    - Write = complete: `wdata` = id.
  - Any other offset (including 0x00) reads 0; writes are ignored.
- Access handshake:
  - `req` sampled at edge n gives `ack`=1 for exactly the cycle after edge n+1, with `rdata` valid; otherwise `rdata`=0.
  - Only one access is outstanding: `req` arriving while `ack`=1 is ignored.
  - Register writes take effect at edge n.
- Claim side effects occur at edge n, using Best from the cycle `req` was high.
  - If Best≠0: clear its pending bit and set its in-flight bit.
  - If Best≠0 and no other source remains eligible, `plic_clear_ext_int_m` pulses high for one cycle (edge n to n+1), coincident with `plic_ext_int_m` falling.
  - If Best=0: return 0, no state change, no pulse.
- Complete is ignored when the id is 0, above `NUM_SRC`, or not in flight; there is no error response.
- Simultaneous events:
  - A new `sync` assertion in the claim cycle does not affect that claim's Best.
  - Set has priority over nothing else: a claim clear of `pending[i]` and a gateway set of the same i cannot coincide, because `inflight` blocks the set.
- Priority/enable/threshold writes affect eligibility from the next cycle; `plic_ext_int_m` updates one cycle later.
  - If such a write causes `plic_ext_int_m` to fall, no clear pulse is produced.

Test Plan:
- Reset: hold `RST` 2 cycles with `irq_src`=0xFF → all outputs 0; reads of 0x84, 0x88 and 0x80 return 0.
- Basic flow:
  - Setup: PRIORITY[3]=5, ENABLE=0x08, THRESHOLD=0.
  - Raise `irq_src[2]` at edge k → `plic_ext_int_m`=1 at edge k+4.
  - Read 0x8C → `rdata`=3; `plic_clear_ext_int_m` pulses 1 cycle; `plic_ext_int_m`=0.
- Arbitration:
  - Setup: PRIORITY[1]=2, PRIORITY[2]=6, PRIORITY[4]=6, ENABLE=0x16, all three lines high.
  - Successive claims → 2, 4, 1, then 0.
  - One clear pulse only, after the claim returning 1; PENDING reads 0x00.
- Threshold/priority 0:
  - THRESHOLD=5 with PRIORITY[3]=5 → `plic_ext_int_m` stays 0 and claim returns 0, while PENDING reads 0x08.
  - Then PRIORITY[3]=0 → still ineligible.
- Complete/re-pend:
  - Claim id 3 with line held high → no re-pend while in flight.
  - Write 0x8C=7 (not in flight) → ignored.
  - Write 0x8C=3 → `pending[3]`=1 next cycle and `plic_ext_int_m`=1 one cycle later.
- Handshake/reset mid-access:
  - Back-to-back `req` pulses → second ignored while `ack`=1.
  - Assert `RST` the cycle after a claim `req` → no `ack`, all state 0.
